ps2_keys: RTL and testbench
===========================

PS2_KEYS -- requirements
Module: ps2_keys

Interface
REQ-001 Parameter: FILTER_LEN, default 8, clk cycles a synchronized ps2_clk level must hold before it is accepted.
REQ-002 Parameter: TIMEOUT, default 50000, clk cycles without an accepted ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 keys  output  8  held key state, 1 = pressed; [3:0] player 1, [7:4] player 2; drives the game's keys[7:0] input.
REQ-008 scan_code  output  8  last correctly received byte.
REQ-009 scan_valid  output  1  one-cycle pulse, scan_code newly updated.
REQ-010 frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-011 ps2_clk and ps2_data SHALL pass through 2-FF synchronizers; filtered ps2_clk changes only after FILTER_LEN consecutive equal synchronized samples.
REQ-012 Sampling SHALL occur on the clk cycle a filtered ps2_clk falling edge is detected, using synchronized ps2_data.
REQ-013 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: sampled 0 -> DATA with bit counter 0; sampled 1 -> stay IDLE, no error.
REQ-015 DATA: shift in 8 bits LSB first; after the 8th -> PARITY.
REQ-016 PARITY: record bit -> STOP; 8 data bits + parity SHALL have odd weight.
REQ-017 STOP: sample 1 with good parity -> scan_code updated, scan_valid pulses next cycle; otherwise frame_err pulses next cycle, scan_code unchanged; both cases -> IDLE.
REQ-018 In any state other than IDLE, TIMEOUT cycles without a sampled edge SHALL force IDLE and pulse frame_err; timeout counter clears on every sampled edge.
REQ-019 Decoder: byte E0 sets ext flag; F0 sets brk flag; neither touches keys.
REQ-020 Any other byte: matched against the map using current ext flag; on match, bit set if brk=0, cleared if brk=1; ext and brk cleared whether matched or not.
REQ-021 Map (ext, code -> bit): 0,1C->0 (A); 0,23->1 (D); 0,1D->2 (W); 0,1B->3 (S); 1,6B->4 (left); 1,74->5 (right); 1,75->6 (up); 1,72->7 (down).
REQ-022 A code matching only with the wrong ext value (e.g. non-extended 6B keypad) SHALL be ignored.
REQ-023 keys SHALL update on the clk cycle after scan_valid; repeated make codes (typematic) leave an already-set bit at 1.
REQ-024 Break for a key not pressed: no change; frame_err does not disturb keys or decoder flags.
REQ-025 Multiple keys SHALL be held simultaneously and independently.

Reset
REQ-026 reset SHALL set FSM to IDLE and clear keys, scan_code, scan_valid, frame_err, ext, brk, shift register, bit and timeout counters, and filter counters; filtered ps2_clk and synchronizers reset to 1.
REQ-027 Reset mid-frame SHALL discard the partial frame; the next accepted start bit begins a new frame.

Structure
REQ-028 Package ps2_keys_pkg SHALL hold the FSM state enumeration, prefix constants E0/F0 and the eight map scan codes.
REQ-029 Sub-module ps2_rx SHALL contain synchronizer, filter, receiver FSM and timeout; ps2_keys holds the decoder and the keys register.

Verification
REQ-030 Frame 1C (parity 0, stop 1), 20 us PS/2 bit period -> scan_code=1C, one scan_valid, keys=01 one cycle later.
REQ-031 Sequence E0,75 then F0,1C -> keys bit6=1, bit0=0 afterwards; E0,F0,75 -> keys=00.
REQ-032 Frame 23 with parity bit inverted -> frame_err pulse, no scan_valid, keys unchanged.
REQ-033 Send start+4 data bits then idle TIMEOUT+10 cycles -> one frame_err, FSM IDLE; next full frame 1D -> keys bit2=1.
REQ-034 ps2_clk glitches of FILTER_LEN-2 cycles low during an idle line -> no sampling, no outputs.
REQ-035 Hold A, W, up, down pressed, assert reset mid-frame of 1B -> keys=00 immediately; frame 1B after release -> keys=08.

Source files
------------

// File: rtl/ps2_keys_pkg.sv
// Shared definitions for the PS/2 keyboard front end: receiver states,
// prefix bytes and the scan-code to key-bit map used by the decoder.
package ps2_keys_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] CODE_E0    = 8'hE0;
  localparam logic [7:0] CODE_F0    = 8'hF0;
  localparam logic [7:0] CODE_A     = 8'h1C;
  localparam logic [7:0] CODE_D     = 8'h23;
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_S     = 8'h1B;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_match_t;

  // The ext flag is part of the key: a keypad 6B without E0 must not alias "left".
  function automatic key_match_t map_key(input logic ext, input logic [7:0] code);
    key_match_t m;
    m.hit = 1'b1;
    m.idx = 3'd0;
    case ({ext, code})
      {1'b0, CODE_A}:     m.idx = 3'd0;
      {1'b0, CODE_D}:     m.idx = 3'd1;
      {1'b0, CODE_W}:     m.idx = 3'd2;
      {1'b0, CODE_S}:     m.idx = 3'd3;
      {1'b1, CODE_LEFT}:  m.idx = 3'd4;
      {1'b1, CODE_RIGHT}: m.idx = 3'd5;
      {1'b1, CODE_UP}:    m.idx = 3'd6;
      {1'b1, CODE_DOWN}:  m.idx = 3'd7;
      default:            m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronizes and deglitches the raw lines, frames
// start/data/parity/stop bits and abandons frames that stall.
module ps2_rx
  import ps2_keys_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          filt_full;

  rx_state_t     state, state_next;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          frame_ok, frame_bad;

  // Synchronizers idle high like the PS/2 lines themselves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign filt_full = (filt_cnt == FW'(FILTER_LEN - 1));

  // The filtered level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_full) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign fall        = clk_filt && !clk_s2 && filt_full;
  assign timeout_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = timeout_hit;
    if (fall && state == STOP) begin
      if (dat_s2 && (^{parity, shift})) frame_ok  = 1'b1;
      else                              frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      bit_cnt    <= '0;
      parity     <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= frame_ok;
      frame_err  <= frame_bad;
      if (frame_ok) scan_code <= shift;
      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TW'(1);
      if (fall) begin
        case (state)
          IDLE: bit_cnt <= 3'd0;
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  parity <= dat_s2;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keys.sv
// PS/2 keyboard to 8-bit held-key vector: receives scan codes and tracks
// make/break (with E0 extension) for the two players' direction keys.
module ps2_keys
  import ps2_keys_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keys,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic       ext, brk;
  key_match_t match;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  always_comb match = map_key(ext, scan_code);

  // Prefixes only arm the flags; any other byte consumes them, mapped or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys <= '0;
      ext  <= 1'b0;
      brk  <= 1'b0;
    end else if (scan_valid) begin
      if (scan_code == CODE_E0) begin
        ext <= 1'b1;
      end else if (scan_code == CODE_F0) begin
        brk <= 1'b1;
      end else begin
        if (match.hit) keys[match.idx] <= !brk;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keys.sv
// Scoreboard bench for ps2_keys: frames are driven at a 40-clk bit period
// and checked against a byte-level keyboard model.
module tb_ps2_keys;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keys;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_keys #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keys      (keys),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  typedef struct {
    bit       is_err;
    bit [7:0] code;
    bit [7:0] keys_after;
  } exp_t;

  exp_t     q[$];
  exp_t     mon_e;
  int       errors = 0;
  int       checks = 0;
  int       events = 0;
  bit [7:0] m_keys;
  bit       m_ext, m_brk;
  bit       keys_pending = 1'b0;
  bit [7:0] keys_want;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key table written straight from the key list: first four plain, last four E0.
  function automatic int ref_bit(input bit ext, input bit [7:0] code);
    bit [7:0] codes[8];
    codes = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h6B, 8'h74, 8'h75, 8'h72};
    for (int i = 0; i < 8; i++)
      if (codes[i] == code && ext == (i >= 4)) return i;
    return -1;
  endfunction

  task automatic model_byte(input bit [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = ref_bit(m_ext, b);
      if (k >= 0) m_keys[k] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input bit v);
    ps2_data = v;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop);
    exp_t e;
    bit   par;
    par = ~(^b) ^ bad_par;
    e.is_err = bad_par | bad_stop;
    if (!e.is_err) model_byte(b);
    e.code       = b;
    e.keys_after = m_keys;
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(!bad_stop);
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("queue_drained", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      keys_pending = 1'b0;
    end else begin
      if (keys_pending) begin
        check("keys_after_valid", int'(keys), int'(keys_want));
        keys_pending = 1'b0;
      end
      if (scan_valid || frame_err) begin
        events++;
        if (q.size() == 0) begin
          check("unexpected_output", int'({scan_valid, frame_err}), 0);
        end else begin
          mon_e = q.pop_front();
          check("frame_err", int'(frame_err), int'(mon_e.is_err));
          check("scan_valid", int'(scan_valid), int'(!mon_e.is_err));
          if (!mon_e.is_err) begin
            check("scan_code", int'(scan_code), int'(mon_e.code));
            keys_pending = 1'b1;
            keys_want    = mon_e.keys_after;
          end else begin
            check("keys_on_err", int'(keys), int'(mon_e.keys_after));
          end
        end
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [7:0] pool[10];
    bit [7:0] b;
    exp_t     e;
    int       r, ev0;
    pool = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h6B, 8'h74, 8'h75, 8'h72};
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    m_keys = '0; m_ext = 1'b0; m_brk = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_keys", int'(keys), 0);
    check("reset_scan_code", int'(scan_code), 0);
    check("reset_scan_valid", int'(scan_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Single make code for A.
    send_frame(8'h1C, 1'b0, 1'b0);
    drain();
    check("a_scan_code", int'(scan_code), 8'h1C);
    check("a_keys", int'(keys), 8'h01);

    // Extended make then plain break, then extended break.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    drain();
    check("up_held", int'(keys[6]), 1);
    check("a_released", int'(keys[0]), 0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    drain();
    check("all_released", int'(keys), 8'h00);

    // Parity error.
    send_frame(8'h23, 1'b1, 1'b0);
    drain();
    check("parity_err_keys", int'(keys), 8'h00);

    // Stalled frame: start plus four data bits.
    e.is_err = 1'b1; e.code = 8'h00; e.keys_after = m_keys;
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    repeat (TIMEOUT + 10) @(posedge clk);
    drain();
    send_frame(8'h1D, 1'b0, 1'b0);
    drain();
    check("w_after_timeout", int'(keys[2]), 1);

    // Short low glitches on an idle line.
    ev0 = events;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 2) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (30) @(posedge clk);
    end
    check("glitch_no_events", events, ev0);
    check("glitch_scan_code", int'(scan_code), 8'h1D);

    // Random byte stream with occasional parity and stop errors.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 11);
      if (r < 10) b = pool[r];
      else        b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      send_frame(b, r == 0, r == 1);
    end
    drain();
    check("random_keys", int'(keys), int'(m_keys));

    // Hold A, W, up, down, then reset in the middle of an S frame.
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b0, 1'b0);
    drain();
    check("held_four", int'(keys & 8'hC5), 8'hC5);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #3 reset = 1'b1;
    #1;
    check("reset_mid_keys", int'(keys), 8'h00);
    check("reset_mid_scan_code", int'(scan_code), 8'h00);
    q.delete();
    m_keys = '0; m_ext = 1'b0; m_brk = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    send_frame(8'h1B, 1'b0, 1'b0);
    drain();
    check("s_after_reset", int'(keys), 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
